// File: rtl/line_window_ctrl.sv
// Line-buffer ring and 3x3 window generator for the streaming image pipeline.
// Raster pixels fill a ring of line buffers; three held lines are read out as one window per column.
//
// state | meaning
// IDLE  | waiting for three complete lines; read column held at 0
// READ  | loading one window per output-register slot until the line's last window
module line_window_ctrl #(
   parameter int PIX_W     = 8,
   parameter int IMG_WIDTH = 512,
   parameter int NUM_LINES = 4,
   parameter int BORDER    = 0
) (
   input  logic               axi_clk,
   input  logic               axi_reset_n,
   input  logic               i_data_valid,
   input  logic [PIX_W-1:0]   i_data,
   output logic               o_data_ready,
   output logic               o_window_valid,
   output logic [9*PIX_W-1:0] o_window,
   input  logic               i_window_ready,
   output logic               o_intr
);

   localparam int COL_W   = $clog2(IMG_WIDTH);
   localparam int BUF_W   = $clog2(NUM_LINES);
   localparam int FILL_W  = $clog2(NUM_LINES + 1);
   localparam int COL_OFS = (BORDER != 0) ? 1 : 0;
   localparam int LAST_RD = (BORDER != 0) ? IMG_WIDTH - 1 : IMG_WIDTH - 3;

   typedef enum logic {IDLE, READ} state_t;

   state_t              state, stateNext;
   logic [PIX_W-1:0]    lineMem [NUM_LINES][IMG_WIDTH];
   logic [COL_W-1:0]    wrCol, rdCol;
   logic [BUF_W-1:0]    wrBuf, rdBuf;
   logic [FILL_W-1:0]   filled;
   logic                accept, wrLast, load, rdLast;
   logic [9*PIX_W-1:0]  windowNext;

   function automatic logic [BUF_W-1:0] bufAdd(input logic [BUF_W-1:0] b, input int k);
      int s;
      s = int'(b) + k;
      if (s >= NUM_LINES) s = s - NUM_LINES;
      return BUF_W'(s);
   endfunction

   // Columns outside the line read as zero; only reachable with horizontal padding.
   function automatic logic [PIX_W-1:0] pixAt(input logic [BUF_W-1:0] b, input int col);
      if (col < 0 || col >= IMG_WIDTH) return '0;
      return lineMem[b][COL_W'(col)];
   endfunction

   assign o_data_ready = (filled < FILL_W'(NUM_LINES));
   assign accept       = i_data_valid && o_data_ready;
   assign wrLast       = accept && (wrCol == COL_W'(IMG_WIDTH - 1));
   assign load         = (state == READ) && (!o_window_valid || i_window_ready);
   assign rdLast       = load && (rdCol == COL_W'(LAST_RD));

   always_ff @(posedge axi_clk) begin
      if (accept) lineMem[wrBuf][wrCol] <= i_data;
   end

   always_comb begin
      windowNext = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            windowNext[PIX_W*(3*r+c) +: PIX_W] = pixAt(bufAdd(rdBuf, r), int'(rdCol) + c - COL_OFS);
         end
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (filled >= FILL_W'(3)) stateNext = READ;
         READ:    if (rdLast) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         state          <= IDLE;
         wrCol          <= '0;
         wrBuf          <= '0;
         rdCol          <= '0;
         rdBuf          <= '0;
         filled         <= '0;
         o_window_valid <= 1'b0;
         o_window       <= '0;
         o_intr         <= 1'b0;
      end else begin
         state  <= stateNext;
         o_intr <= rdLast;

         if (accept) begin
            if (wrLast) begin
               wrCol <= '0;
               wrBuf <= bufAdd(wrBuf, 1);
            end else begin
               wrCol <= wrCol + 1'b1;
            end
         end

         // A line written and a line released on the same edge cancel out.
         case ({wrLast, rdLast})
            2'b10:   filled <= filled + 1'b1;
            2'b01:   filled <= filled - 1'b1;
            default: filled <= filled;
         endcase

         if (state == IDLE) begin
            rdCol <= '0;
         end else if (load) begin
            rdCol <= rdCol + 1'b1;
         end
         if (rdLast) rdBuf <= bufAdd(rdBuf, 1);

         if (load) begin
            o_window       <= windowNext;
            o_window_valid <= 1'b1;
         end else if (i_window_ready) begin
            o_window_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_line_window_ctrl.sv
// Scoreboard bench for line_window_ctrl: one valid-only and one zero-pad instance, 8-pixel lines, 4-buffer ring.
// Expected windows are pushed as lines complete; a negedge monitor pops and compares on each transfer.
module tb_line_window_ctrl;

   localparam int IW = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dv   [2];
   logic [7:0]  din  [2];
   logic        drdy [2];
   logic        wv   [2];
   logic [71:0] win  [2];
   logic        wrdy [2];
   logic        intr [2];

   always #5 clk = ~clk;

   line_window_ctrl #(.PIX_W(8), .IMG_WIDTH(IW), .NUM_LINES(4), .BORDER(0)) dut0 (
      .axi_clk(clk), .axi_reset_n(rst_n), .i_data_valid(dv[0]), .i_data(din[0]),
      .o_data_ready(drdy[0]), .o_window_valid(wv[0]), .o_window(win[0]),
      .i_window_ready(wrdy[0]), .o_intr(intr[0]));

   line_window_ctrl #(.PIX_W(8), .IMG_WIDTH(IW), .NUM_LINES(4), .BORDER(1)) dut1 (
      .axi_clk(clk), .axi_reset_n(rst_n), .i_data_valid(dv[1]), .i_data(din[1]),
      .o_data_ready(drdy[1]), .o_window_valid(wv[1]), .o_window(win[1]),
      .i_window_ready(wrdy[1]), .o_intr(intr[1]));

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          accCyc = 0;
   logic [71:0] expQ0[$];
   logic [71:0] expQ1[$];
   int          winCount[2], intrCount[2], firstValidCyc[2], lastWinCyc[2], intrCyc[2];
   int          readyMode[2];
   logic [71:0] firstWin[2], lastWin[2], prevWin[2];
   bit          prevHold[2], intrReady[2];

   always @(posedge clk) cyc <= cyc + 1;

   // 0 = hold low, 1 = hold high, 2 = random, applied just after each rising edge
   always @(posedge clk) begin
      #1;
      for (int s = 0; s < 2; s++)
         wrdy[s] = (readyMode[s] == 2) ? 1'($urandom_range(0, 1)) : (readyMode[s] == 1);
   end

   task automatic chkI(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chkW(input string nm, input logic [71:0] act, input logic [71:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic timeoutFail(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: wait bound expired", nm);
   endtask

   function automatic logic [71:0] pack9(input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5,
                                         input int a6, input int a7, input int a8);
      return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
   endfunction

   // Reference: pixel = 16*line + col, rows top..top+2, zero outside the line when padded.
   task automatic pushWindows(input int s, input int top);
      logic [71:0] w;
      int col, nWin;
      nWin = (s == 1) ? IW : IW - 2;
      for (int c = 0; c < nWin; c++) begin
         w = '0;
         for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++) begin
               col = (s == 1) ? c - 1 + k : c + k;
               if (col >= 0 && col < IW) w[8*(3*r+k) +: 8] = 8'(16 * (top + r) + col);
            end
         if (s == 0) expQ0.push_back(w);
         else        expQ1.push_back(w);
      end
   endtask

   task automatic monitorPort(input int s);
      logic [71:0] e;
      if (prevHold[s]) begin
         chkI("hold_valid", int'(wv[s]), 1);
         chkW("hold_window", win[s], prevWin[s]);
      end
      if (wv[s] && firstValidCyc[s] < 0) firstValidCyc[s] = cyc;
      if (intr[s]) begin
         intrCount[s]++;
         intrCyc[s]   = cyc;
         intrReady[s] = drdy[s];
      end
      if (wv[s] && wrdy[s]) begin
         if ((s == 0) ? (expQ0.size() == 0) : (expQ1.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL unexpected_window port %0d: got %h expected none", s, win[s]);
         end else begin
            e = (s == 0) ? expQ0.pop_front() : expQ1.pop_front();
            chkW("window", win[s], e);
         end
         if (winCount[s] == 0) firstWin[s] = win[s];
         lastWin[s]    = win[s];
         lastWinCyc[s] = cyc;
         winCount[s]++;
      end
      prevHold[s] = wv[s] && !wrdy[s];
      prevWin[s]  = win[s];
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1)
         for (int s = 0; s < 2; s++) monitorPort(s);
   end

   task automatic sendPix(input int s, input logic [7:0] p, input bit gaps);
      int g;
      if (gaps) begin
         g = $urandom_range(0, 2);
         dv[s] = 1'b0;
         repeat (g) begin @(posedge clk); #1; end
      end
      dv[s]  = 1'b1;
      din[s] = p;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (drdy[s]) begin
            @(posedge clk); #1;
            accCyc = cyc;
            return;
         end
         @(posedge clk); #1;
      end
      dv[s] = 1'b0;
      timeoutFail("accept_timeout");
   endtask

   task automatic sendLines(input int s, input int n, input bit gaps);
      for (int l = 0; l < n; l++) begin
         for (int c = 0; c < IW; c++) sendPix(s, 8'(16 * l + c), gaps);
         if (l >= 2) pushWindows(s, l - 2);
      end
      dv[s] = 1'b0;
   endtask

   task automatic waitWins(input int s, input int n);
      bit done;
      done = 0;
      for (int t = 0; t < 2000 && !done; t++) begin
         @(negedge clk); #1;
         if (winCount[s] >= n && ((s == 0) ? expQ0.size() : expQ1.size()) == 0) done = 1;
      end
      if (!done) timeoutFail("window_drain_timeout");
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic resetPhase();
      @(posedge clk); #1;
      rst_n = 1'b0;
      expQ0.delete();
      expQ1.delete();
      for (int s = 0; s < 2; s++) begin
         dv[s] = 1'b0;
         winCount[s] = 0; intrCount[s] = 0; firstValidCyc[s] = -1;
         lastWinCyc[s] = -1; intrCyc[s] = -1; prevHold[s] = 0; intrReady[s] = 0;
      end
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chkI("rst_data_ready", int'(drdy[s]), 1);
         chkI("rst_window_valid", int'(wv[s]), 0);
         chkI("rst_intr", int'(intr[s]), 0);
         chkW("rst_window", win[s], '0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic validOnlyPhase();
      int acc24;
      readyMode[0] = 1;
      sendLines(0, 3, 0);
      acc24 = accCyc;
      waitWins(0, 6);
      chkI("vo_count", winCount[0], 6);
      chkW("vo_first", firstWin[0], pack9(0, 1, 2, 16, 17, 18, 32, 33, 34));
      chkW("vo_last", lastWin[0], pack9(5, 6, 7, 21, 22, 23, 37, 38, 39));
      chkI("vo_latency", firstValidCyc[0] - acc24, 2);
      chkI("vo_throughput", lastWinCyc[0] - firstValidCyc[0], 5);
      chkI("vo_intr_count", intrCount[0], 1);
      chkI("vo_intr_timing", intrCyc[0], lastWinCyc[0]);
   endtask

   initial begin
      int acc;
      bit seen;
      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         dv[s] = 1'b0; din[s] = '0; readyMode[s] = 1;
      end

      resetPhase();
      validOnlyPhase();

      readyMode[1] = 1;
      sendLines(1, 3, 0);
      acc = accCyc;
      waitWins(1, 8);
      chkI("zp_count", winCount[1], 8);
      chkW("zp_first", firstWin[1], pack9(0, 0, 1, 0, 16, 17, 0, 32, 33));
      chkW("zp_last", lastWin[1], pack9(6, 7, 0, 22, 23, 0, 38, 39, 0));
      chkI("zp_latency", firstValidCyc[1] - acc, 2);
      chkI("zp_intr_count", intrCount[1], 1);

      resetPhase();
      readyMode[0] = 0;
      sendLines(0, 4, 0);
      @(negedge clk);
      chkI("full_ready_low", int'(drdy[0]), 0);
      repeat (20) @(negedge clk);
      chkI("full_hold_valid", int'(wv[0]), 1);
      chkW("full_hold_window", win[0], pack9(0, 1, 2, 16, 17, 18, 32, 33, 34));
      chkI("full_no_transfer", winCount[0], 0);
      @(posedge clk); #1;
      readyMode[0] = 1;
      seen = 0;
      for (int t = 0; t < 200 && !seen; t++) begin
         @(negedge clk); #1;
         if (intrCount[0] >= 1) seen = 1;
      end
      if (!seen) timeoutFail("full_intr_timeout");
      chkI("full_windows_before_intr", winCount[0], 6);
      chkI("full_ready_with_intr", int'(intrReady[0]), 1);
      waitWins(0, 12);
      chkI("full_total_windows", winCount[0], 12);
      chkI("full_intr_total", intrCount[0], 2);
      chkI("full_ready_after", int'(drdy[0]), 1);

      resetPhase();
      readyMode[0] = 2;
      sendLines(0, 6, 1);
      waitWins(0, 24);
      chkI("rand_count", winCount[0], 24);
      chkI("rand_intr_count", intrCount[0], 4);
      readyMode[0] = 1;

      resetPhase();
      readyMode[0] = 0;
      sendLines(0, 3, 0);
      seen = 0;
      for (int t = 0; t < 50 && !seen; t++) begin
         @(negedge clk);
         if (wv[0]) seen = 1;
      end
      if (!seen) timeoutFail("midread_valid_timeout");
      resetPhase();
      validOnlyPhase();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
